// File: rtl/clocktime_pkg.sv
// clocktime_pkg: shared mode/field encodings, BCD limits and validation helper
package clocktime_pkg;
   typedef enum logic [1:0] {RUN = 2'b00, LOAD = 2'b01, HOLD = 2'b10, ADJUST = 2'b11} mode_t;
   typedef enum logic [1:0] {SEC = 2'b00, MIN = 2'b01, HOUR = 2'b10, NONE = 2'b11} field_t;
   localparam logic [7:0] BCD_59 = 8'h59;
   localparam logic [7:0] BCD_23 = 8'h23;
   localparam logic [7:0] BCD_12 = 8'h12;
   function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] max);
      return value[7:4] <= 4'd9 && value[3:0] <= 4'd9 && value <= max;
   endfunction
endpackage

// File: rtl/bcd_wrap_inc.sv
// bcd_wrap_inc: two-digit BCD increment that wraps to 00 after MAX
module bcd_wrap_inc #(
   parameter logic [7:0] MAX = 8'h59
) (
   input  logic [7:0] val,
   output logic [7:0] nxt,
   output logic       wrap
);
   assign wrap = val == MAX;
   assign nxt  = wrap ? 8'h00 : val[3:0] == 4'd9 ? {val[7:4] + 4'd1, 4'h0} : {val[7:4], val[3:0] + 4'd1};
endmodule

// File: rtl/clocktime_multi.sv
// clocktime_multi: prescaled BCD time-of-day keeper with load, hold, adjust and 12h display
module clocktime_multi
   import clocktime_pkg::*;
#(
   parameter int         TICK_DIV   = 1,
   parameter logic [7:0] RESET_HOUR = 8'h00,
   parameter logic [7:0] RESET_MIN  = 8'h00,
   parameter logic [7:0] RESET_SEC  = 8'h00
) (
   input  logic        clk_1hz,
   input  logic        rst,
   input  logic [1:0]  clk_mode,
   input  logic [23:0] time_in,
   input  logic [1:0]  adj_field,
   input  logic        adj_inc,
   input  logic        fmt_12h,
   output logic [23:0] time_out,
   output logic [23:0] disp_out,
   output logic        pm,
   output logic        day_tick,
   output logic        load_err
);
   localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   if (TICK_DIV < 1 || TICK_DIV > 65536) begin : g_bad_div
      $error("TICK_DIV out of range");
   end
   if (!bcd_valid(RESET_HOUR, BCD_23) || !bcd_valid(RESET_MIN, BCD_59) || !bcd_valid(RESET_SEC, BCD_59)) begin : g_bad_reset
      $error("illegal RESET_* time");
   end
   logic [TW-1:0] tick_cnt;
   logic [7:0]    s_nxt, m_nxt, h_nxt, hour, hour_12;
   logic          s_wrap, m_wrap, h_wrap, load_ok;
   mode_t         mode;
   field_t        field;
   assign mode    = mode_t'(clk_mode);
   assign field   = field_t'(adj_field);
   assign hour    = time_out[23:16];
   assign load_ok = bcd_valid(time_in[23:16], BCD_23) && bcd_valid(time_in[15:8], BCD_59) && bcd_valid(time_in[7:0], BCD_59);
   bcd_wrap_inc #(.MAX(BCD_59)) u_sec  (.val(time_out[7:0]),   .nxt(s_nxt), .wrap(s_wrap));
   bcd_wrap_inc #(.MAX(BCD_59)) u_min  (.val(time_out[15:8]),  .nxt(m_nxt), .wrap(m_wrap));
   bcd_wrap_inc #(.MAX(BCD_23)) u_hour (.val(time_out[23:16]), .nxt(h_nxt), .wrap(h_wrap));
   // 13..19 and 22..23 drop by BCD 12; 20/21 cross a decade so drop by BCD 18
   always_comb hour_12 = hour == 8'h00 ? 8'h12 : hour <= 8'h12 ? hour : (hour == 8'h20 || hour == 8'h21) ? hour - 8'h18 : hour - 8'h12;
   assign disp_out = fmt_12h ? {hour_12, time_out[15:0]} : time_out;
   assign pm       = hour >= BCD_12;
   always_ff @(posedge clk_1hz) begin
      if (!rst) begin
         time_out <= {RESET_HOUR, RESET_MIN, RESET_SEC};
         tick_cnt <= '0;
         day_tick <= 1'b0;
         load_err <= 1'b0;
      end else begin
         day_tick <= 1'b0;
         case (mode)
            RUN: if (tick_cnt == TICK_LAST) begin
               tick_cnt <= '0;
               time_out <= {(s_wrap && m_wrap) ? h_nxt : hour, s_wrap ? m_nxt : time_out[15:8], s_nxt};
               day_tick <= s_wrap && m_wrap && h_wrap;
            end else tick_cnt <= tick_cnt + 1'b1;
            LOAD: if (load_ok) begin
               time_out <= time_in;
               tick_cnt <= '0;
               load_err <= 1'b0;
            end else load_err <= 1'b1;
            HOLD: ;
            ADJUST: if (adj_inc) begin
               case (field)
                  SEC:  time_out[7:0]   <= s_nxt;
                  MIN:  time_out[15:8]  <= m_nxt;
                  HOUR: time_out[23:16] <= h_nxt;
                  NONE: ;
               endcase
            end
         endcase
      end
   end
endmodule

// File: tb/tb_clocktime_multi.sv
// tb_clocktime_multi: two instances (1-cycle and 4-cycle tick) against a seconds-count model
module tb_clocktime_multi;
   logic        clk_1hz = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  clk_mode = 2'b00;
   logic [23:0] time_in = '0;
   logic [1:0]  adj_field = 2'b11;
   logic        adj_inc = 1'b0;
   logic        fmt_12h = 1'b0;
   logic [23:0] tout [2];
   logic [23:0] dout [2];
   logic        pm_o [2];
   logic        dtk [2];
   logic        lerr [2];
   int checks = 0;
   int errors = 0;
   int hh [2], mm [2], ss [2], ph [2];
   bit er [2], dt [2];
   int div [2] = '{1, 4};
   int rh [2] = '{0, 7};

   clocktime_multi u0 (
      .clk_1hz(clk_1hz), .rst(rst), .clk_mode(clk_mode), .time_in(time_in), .adj_field(adj_field),
      .adj_inc(adj_inc), .fmt_12h(fmt_12h), .time_out(tout[0]), .disp_out(dout[0]), .pm(pm_o[0]),
      .day_tick(dtk[0]), .load_err(lerr[0])
   );
   clocktime_multi #(.TICK_DIV(4), .RESET_HOUR(8'h07)) u1 (
      .clk_1hz(clk_1hz), .rst(rst), .clk_mode(clk_mode), .time_in(time_in), .adj_field(adj_field),
      .adj_inc(adj_inc), .fmt_12h(fmt_12h), .time_out(tout[1]), .disp_out(dout[1]), .pm(pm_o[1]),
      .day_tick(dtk[1]), .load_err(lerr[1])
   );

   initial forever #5 clk_1hz = ~clk_1hz;

   task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] bcd(input int v);
      return 8'((v / 10) * 16 + v % 10);
   endfunction

   function automatic int dec(input logic [7:0] b);
      return (b[7:4] > 4'd9 || b[3:0] > 4'd9) ? 1000 : int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   task automatic model(input int k);
      int t, h, m, s;
      if (!rst) begin
         hh[k] = rh[k]; mm[k] = 0; ss[k] = 0; ph[k] = 0; er[k] = 0; dt[k] = 0;
      end else begin
         dt[k] = 0;
         case (clk_mode)
            2'b00: if (ph[k] == div[k] - 1) begin
               ph[k] = 0;
               t = hh[k] * 3600 + mm[k] * 60 + ss[k] + 1;
               if (t == 86400) begin t = 0; dt[k] = 1; end
               hh[k] = t / 3600; mm[k] = (t / 60) % 60; ss[k] = t % 60;
            end else ph[k]++;
            2'b01: begin
               h = dec(time_in[23:16]); m = dec(time_in[15:8]); s = dec(time_in[7:0]);
               if (h <= 23 && m <= 59 && s <= 59) begin
                  hh[k] = h; mm[k] = m; ss[k] = s; ph[k] = 0; er[k] = 0;
               end else er[k] = 1;
            end
            2'b10: ;
            2'b11: if (adj_inc) begin
               if (adj_field == 2'd0) ss[k] = (ss[k] + 1) % 60;
               if (adj_field == 2'd1) mm[k] = (mm[k] + 1) % 60;
               if (adj_field == 2'd2) hh[k] = (hh[k] + 1) % 24;
            end
         endcase
      end
   endtask

   task automatic step();
      logic [23:0] et;
      int h12;
      @(posedge clk_1hz);
      model(0);
      model(1);
      #1;
      for (int k = 0; k < 2; k++) begin
         et = {bcd(hh[k]), bcd(mm[k]), bcd(ss[k])};
         h12 = hh[k] % 12 == 0 ? 12 : hh[k] % 12;
         chk($sformatf("time%0d", k), tout[k], et);
         chk($sformatf("disp%0d", k), dout[k], fmt_12h ? {bcd(h12), et[15:0]} : et);
         chk($sformatf("pm%0d", k), 24'(pm_o[k]), 24'(hh[k] >= 12));
         chk($sformatf("day_tick%0d", k), 24'(dtk[k]), 24'(dt[k]));
         chk($sformatf("load_err%0d", k), 24'(lerr[k]), 24'(er[k]));
      end
   endtask

   task automatic cyc(input logic [1:0] m, input logic [23:0] t, input logic [1:0] f, input logic i, input int n);
      clk_mode = m; time_in = t; adj_field = f; adj_inc = i;
      repeat (n) step();
   endtask

   initial begin
      #2;
      rst = 1'b0;
      cyc(2'b00, 24'h0, 2'b11, 1'b0, 2);
      rst = 1'b1;
      cyc(2'b01, 24'h235958, 2'b11, 1'b0, 1);
      cyc(2'b00, 24'h0, 2'b11, 1'b0, 3);
      chk("roll_end", tout[0], 24'h000001);
      cyc(2'b01, 24'h000009, 2'b11, 1'b0, 1);
      cyc(2'b00, 24'h0, 2'b11, 1'b0, 8);
      chk("prescale8", tout[1], 24'h000011);
      cyc(2'b00, 24'h0, 2'b11, 1'b0, 2);
      cyc(2'b10, 24'h0, 2'b11, 1'b0, 2);
      cyc(2'b00, 24'h0, 2'b11, 1'b0, 2);
      chk("hold_resume", tout[1], 24'h000012);
      cyc(2'b00, 24'h0, 2'b11, 1'b0, 2);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("rst_time", tout[1], 24'h070000);
      cyc(2'b00, 24'h0, 2'b11, 1'b0, 4);
      cyc(2'b01, 24'h236000, 2'b11, 1'b0, 1);
      cyc(2'b01, 24'h120000, 2'b11, 1'b0, 1);
      cyc(2'b01, 24'h005959, 2'b11, 1'b0, 1);
      cyc(2'b11, 24'h0, 2'b00, 1'b1, 1);
      chk("adj_sec", tout[0], 24'h005900);
      cyc(2'b01, 24'h230000, 2'b11, 1'b0, 1);
      cyc(2'b11, 24'h0, 2'b10, 1'b1, 1);
      cyc(2'b11, 24'h0, 2'b11, 1'b1, 2);
      cyc(2'b11, 24'h0, 2'b01, 1'b0, 1);
      cyc(2'b10, 24'h0, 2'b00, 1'b1, 1);
      fmt_12h = 1'b1;
      cyc(2'b01, 24'h000000, 2'b11, 1'b0, 1);
      cyc(2'b01, 24'h120000, 2'b11, 1'b0, 1);
      cyc(2'b01, 24'h130510, 2'b11, 1'b0, 1);
      cyc(2'b01, 24'h235959, 2'b11, 1'b0, 1);
      chk("disp_2359", dout[0], 24'h115959);
      for (int h = 0; h < 24; h++) cyc(2'b01, {bcd(h), 8'h30, 8'h00}, 2'b11, 1'b0, 1);
      repeat (400) begin
         int r;
         rst = $urandom_range(0, 39) != 0;
         r = $urandom_range(0, 9);
         clk_mode = r < 5 ? 2'b00 : r == 5 ? 2'b01 : r < 8 ? 2'b10 : 2'b11;
         r = $urandom_range(0, 3);
         time_in = r == 0 ? 24'($urandom) : r == 1 ? {8'h23, 8'h59, bcd($urandom_range(50, 59))}
                 : {bcd($urandom_range(0, 23)), bcd($urandom_range(0, 59)), bcd($urandom_range(0, 59))};
         adj_field = 2'($urandom);
         adj_inc = 1'($urandom);
         fmt_12h = 1'($urandom);
         step();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
